uart_rx_deser: RTL

Serial-to-parallel receive front end for the memory-mapped UART peripheral. It sits between the uart_rx pad and the peripheral's RXDT/STAT registers.
- Synchronises the asynchronous line and detects the start bit.
- Samples each bit at mid-bit with a 3-tap majority vote.
- Presents the received byte in a holding register with a valid/ack handshake plus sticky error flags.
The peripheral reads rx_data/status through this block instead of sampling the pin directly.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_rx_deser_if.sv | 34 +++
 rtl/uart_rx_sync.sv | 41 ++++
 rtl/uart_rx_deser.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the memory-mapped UART peripheral:
//   - receive state machine encoding
//   - default baud divisor and data width
//   - peripheral register map (base address and offsets)
//   - 3-input majority helper used by the mid-bit sampler
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_IDLE = 3'd4
    } uart_rx_state_e;

    localparam int UART_BAUD_DEFAULT = 208;
    localparam int UART_DATA_BITS    = 8;

    localparam logic [31:0] UART_BASE_ADDR = 32'hffff_0020;
    localparam logic [7:0]  UART_RXDT_OFS  = 8'h00;
    localparam logic [7:0]  UART_TXDT_OFS  = 8'h04;
    localparam logic [7:0]  UART_CTRL_OFS  = 8'h08;
    localparam logic [7:0]  UART_STAT_OFS  = 8'h0c;

    // Majority of three samples; a single corrupted sample cannot flip the bit.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_deser_if.sv
// -----------------------------------------------------------------------------
// uart_rx_deser_if
// Holding-register side of the UART receive front end.
//   rx_data      : received byte, LSB = first data bit
//   rx_valid     : holding register full (level)
//   rx_ack       : consumer has taken rx_data (single-cycle strobe)
//   err_clr      : clears the sticky error flags
//   rx_frame_err : sticky, stop bit sampled low
//   rx_overrun   : sticky, byte completed while holding register full
//   rx_busy      : receive state machine not idle
// master = the receiver, slave = the register block consuming the byte.
// -----------------------------------------------------------------------------
interface uart_rx_deser_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] rx_data;
    logic                      rx_valid;
    logic                      rx_ack;
    logic                      err_clr;
    logic                      rx_frame_err;
    logic                      rx_overrun;
    logic                      rx_busy;

    modport master (
        output rx_data, rx_valid, rx_frame_err, rx_overrun, rx_busy,
        input  rx_ack, err_clr
    );

    modport slave (
        input  rx_data, rx_valid, rx_frame_err, rx_overrun, rx_busy,
        output rx_ack, err_clr
    );

endinterface

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Brings the asynchronous serial line into the clk domain and flags the
// falling edge that marks a potential start bit.
//   clk  : system clock
//   rst  : asynchronous, active-low reset
//   rx   : asynchronous serial line, idle high
//   sync : synchronised line level
//   fall : synchronised line went 1 -> 0 (one cycle wide)
// -----------------------------------------------------------------------------
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic sync,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev_q;

    // NOTE: every flop here resets to 1 (line idle) so leaving reset can never
    // look like a falling edge and fake a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q      <= '1;
            sync_prev_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make each stage take the previous
            // stage's old value, giving a true shift chain.
            sync_q      <= {sync_q[SYNC_STAGES-2:0], rx};
            sync_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];
    assign fall = sync_prev_q & ~sync;

endmodule

// File: rtl/uart_rx_deser.sv
// -----------------------------------------------------------------------------
// uart_rx_deser
// Serial-to-parallel receive front end of the UART peripheral (8N1).
// Detects the start bit, samples every bit at mid-bit with a 3-tap majority
// vote and presents the byte in a holding register with valid/ack handshake
// and sticky frame-error / overrun flags.
//   clk : system clock
//   rst : asynchronous, active-low reset
//   en  : receiver enable; dropping it mid-frame abandons the frame
//   rx  : asynchronous serial line, idle high
//   bus : holding register, handshake and status (uart_rx_deser_if.master)
// -----------------------------------------------------------------------------
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_BAUD_DEFAULT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            rx,
    uart_rx_deser_if.master bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int MID   = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] SMP_0    = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] SMP_1    = CNT_W'(MID);
    localparam logic [CNT_W-1:0] SMP_DEC  = CNT_W'(MID + 1);

    localparam logic [2:0] IDLE      = RX_IDLE;
    localparam logic [2:0] START     = RX_START;
    localparam logic [2:0] DATA      = RX_DATA;
    localparam logic [2:0] STOP      = RX_STOP;
    localparam logic [2:0] WAIT_IDLE = RX_WAIT_IDLE;

    // ---------------------------------------------------------------- line sync
    logic sync;
    logic fall;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .sync (sync),
        .fall (fall)
    );

    // ------------------------------------------------------------ frame state
    logic [2:0]                state_q, state_d;
    logic [CNT_W-1:0]          cyc_q,   cyc_d;
    logic [2:0]                bit_q,   bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      smp0_q,  smp0_d;
    logic                      smp1_q,  smp1_d;
    logic                      busy_q;

    logic maj;
    logic decide;
    logic bit_end;
    logic byte_done;
    logic frame_err_set;

    // The third tap is the live synchronised value, so the vote is complete
    // in the same cycle as the decision point.
    assign maj     = maj3(smp0_q, smp1_q, sync);
    assign decide  = (cyc_q == SMP_DEC);
    assign bit_end = (cyc_q == CYC_LAST);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned (which would infer a latch).
        state_d       = state_q;
        cyc_d         = cyc_q;
        bit_d         = bit_q;
        shift_d       = shift_q;
        smp0_d        = smp0_q;
        smp1_d        = smp1_q;
        byte_done     = 1'b0;
        frame_err_set = 1'b0;

        if (cyc_q == SMP_0) smp0_d = sync;
        if (cyc_q == SMP_1) smp1_d = sync;

        case (state_q)
            IDLE: begin
                if (en && fall) begin
                    state_d = START;
                    cyc_d   = '0;
                    bit_d   = '0;
                end
            end

            START: begin
                cyc_d = bit_end ? '0 : cyc_q + 1'b1;
                if (decide && maj) begin
                    // Line back high at mid start bit: noise, not a frame.
                    state_d = IDLE;
                    cyc_d   = '0;
                end else if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end

            DATA: begin
                cyc_d = bit_end ? '0 : cyc_q + 1'b1;
                if (decide) shift_d = {maj, shift_q[UART_DATA_BITS-1:1]};
                if (bit_end) begin
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 1'b1;
                end
            end

            STOP: begin
                cyc_d = cyc_q + 1'b1;
                if (decide) begin
                    cyc_d = '0;
                    if (maj) begin
                        byte_done = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        frame_err_set = 1'b1;
                        state_d       = WAIT_IDLE;
                    end
                end
            end

            WAIT_IDLE: begin
                // A held-low line (break) must end before a new start edge
                // can be believed.
                cyc_d = '0;
                if (sync) state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                cyc_d   = '0;
            end
        endcase

        // Disabling abandons the frame silently; the holding side is untouched.
        if (!en && (state_q != IDLE)) begin
            state_d       = IDLE;
            cyc_d         = '0;
            bit_d         = '0;
            byte_done     = 1'b0;
            frame_err_set = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            smp0_q  <= 1'b0;
            smp1_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            smp0_q  <= smp0_d;
            smp1_q  <= smp1_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    // -------------------------------------------------------- holding register
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      ferr_q, ferr_d;
    logic                      ovr_q, ovr_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;

        if (bus.err_clr) begin
            ferr_d = 1'b0;
            ovr_d  = 1'b0;
        end

        if (byte_done) begin
            // An ack in the completion cycle frees the register just in time.
            if (!valid_q || bus.rx_ack) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (bus.rx_ack) begin
            valid_d = 1'b0;
        end

        // Set events are applied last so they win over err_clr.
        if (frame_err_set) ferr_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.rx_data      = data_q;
    assign bus.rx_valid     = valid_q;
    assign bus.rx_frame_err = ferr_q;
    assign bus.rx_overrun   = ovr_q;
    assign bus.rx_busy      = busy_q;

endmodule
